// File: rtl/mmio_sysctl.sv
// CPU memory-port splitter: a small system-control window (DONE, cycle counter, status)
// is served locally; everything else goes to RAM, guarded by an access timeout.
module mmio_sysctl #(
  parameter logic [31:0] MMIO_BASE   = 32'h0000_0010,
  parameter int          RAM_TIMEOUT = 1024,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        ram_valid,
  output logic        ram_instr,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  output logic [3:0]  ram_wstrb,
  input  logic        ram_ready,
  input  logic [31:0] ram_rdata,
  output logic        done,
  output logic [31:0] done_code,
  output logic [63:0] cycle_count,
  output logic        bus_timeout
);

  typedef enum logic [1:0] {IDLE, MMIO_RESP, RAM_WAIT, RAM_RESP} state_t;

  localparam int TW = $clog2(RAM_TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(RAM_TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          ram_instr_q, ram_instr_d;
  logic [31:0]   ram_addr_q, ram_addr_d;
  logic [31:0]   ram_wdata_q, ram_wdata_d;
  logic [3:0]    ram_wstrb_q, ram_wstrb_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          done_q, done_d;
  logic [31:0]   code_q, code_d;
  logic [63:0]   cycle_q, cycle_d;
  logic [31:0]   hi_q, hi_d;
  logic          timeout_q, timeout_d;

  logic          hit;
  logic          is_wr;
  logic [31:0]   merged;

  assign hit   = (mem_addr[31:4] == MMIO_BASE[31:4]);
  assign is_wr = |mem_wstrb;

  // DONE is byte-merged over zero, not over its previous contents.
  always_comb begin
    merged = 32'h0;
    for (int i = 0; i < 4; i++) begin
      if (mem_wstrb[i]) merged[i*8 +: 8] = mem_wdata[i*8 +: 8];
    end
  end

  always_comb begin
    state_d     = state_q;
    rdata_d     = rdata_q;
    ram_instr_d = ram_instr_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wstrb_d = ram_wstrb_q;
    tmo_d       = tmo_q;
    done_d      = done_q;
    code_d      = code_q;
    hi_d        = hi_q;
    timeout_d   = timeout_q;
    cycle_d     = done_q ? cycle_q : cycle_q + 64'd1;

    unique case (state_q)
      IDLE: begin
        if (mem_valid && hit) begin
          state_d = MMIO_RESP;
          rdata_d = 32'h0;
          unique case (mem_addr[3:2])
            2'd0: begin
              if (is_wr) begin
                if (!done_q) begin
                  done_d = 1'b1;
                  code_d = merged;
                end
              end else begin
                rdata_d = code_q;
              end
            end
            2'd1: begin
              // Snapshot the high word so a following CYCLE_HI read pairs with this LO.
              if (!is_wr) begin
                rdata_d = cycle_q[31:0];
                hi_d    = cycle_q[63:32];
              end
            end
            2'd2: if (!is_wr) rdata_d = hi_q;
            default: if (!is_wr) rdata_d = {30'b0, timeout_q, done_q};
          endcase
        end else if (mem_valid) begin
          state_d     = RAM_WAIT;
          ram_instr_d = mem_instr;
          ram_addr_d  = mem_addr;
          ram_wdata_d = mem_wdata;
          ram_wstrb_d = mem_wstrb;
          tmo_d       = '0;
        end
      end
      MMIO_RESP: state_d = IDLE;
      RAM_WAIT: begin
        if (ram_ready) begin
          state_d = RAM_RESP;
          rdata_d = (|ram_wstrb_q) ? 32'h0 : ram_rdata;
        end else if (tmo_q == TMO_LAST) begin
          state_d   = RAM_RESP;
          rdata_d   = (|ram_wstrb_q) ? 32'h0 : ERR_DATA;
          timeout_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdata_q     <= 32'h0;
      ram_instr_q <= 1'b0;
      ram_addr_q  <= 32'h0;
      ram_wdata_q <= 32'h0;
      ram_wstrb_q <= 4'h0;
      tmo_q       <= '0;
      done_q      <= 1'b0;
      code_q      <= 32'h0;
      cycle_q     <= 64'h0;
      hi_q        <= 32'h0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdata_q     <= rdata_d;
      ram_instr_q <= ram_instr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wstrb_q <= ram_wstrb_d;
      tmo_q       <= tmo_d;
      done_q      <= done_d;
      code_q      <= code_d;
      cycle_q     <= cycle_d;
      hi_q        <= hi_d;
      timeout_q   <= timeout_d;
    end
  end

  assign mem_ready   = (state_q == MMIO_RESP) || (state_q == RAM_RESP);
  assign mem_rdata   = rdata_q;
  assign ram_valid   = (state_q == RAM_WAIT);
  assign ram_instr   = ram_instr_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign ram_wstrb   = ram_wstrb_q;
  assign done        = done_q;
  assign done_code   = code_q;
  assign cycle_count = cycle_q;
  assign bus_timeout = timeout_q;

endmodule

// File: tb/tb_mmio_sysctl.sv
// Directed bench for mmio_sysctl: a vector table of single bus transactions plus
// hand-written sequences for counter freeze, HI snapshot across a carry and reset mid-access.
module tb_mmio_sysctl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_instr = 1'b0;
  logic [31:0] mem_addr = 32'h0;
  logic [31:0] mem_wdata = 32'h0;
  logic [3:0]  mem_wstrb = 4'h0;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic        ram_valid;
  logic        ram_instr;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic [3:0]  ram_wstrb;
  logic        ram_ready = 1'b0;
  logic [31:0] ram_rdata = 32'h0;
  logic        done;
  logic [31:0] done_code;
  logic [63:0] cycle_count;
  logic        bus_timeout;

  int n_vec = 0;
  int n_bad = 0;
  int ram_delay = 0;
  int ram_cnt = 0;

  mmio_sysctl #(
    .MMIO_BASE  (32'h0000_0010),
    .RAM_TIMEOUT(8),
    .ERR_DATA   (32'hDEAD_BEEF)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_valid  (mem_valid),
    .mem_instr  (mem_instr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ready  (mem_ready),
    .mem_rdata  (mem_rdata),
    .ram_valid  (ram_valid),
    .ram_instr  (ram_instr),
    .ram_addr   (ram_addr),
    .ram_wdata  (ram_wdata),
    .ram_wstrb  (ram_wstrb),
    .ram_ready  (ram_ready),
    .ram_rdata  (ram_rdata),
    .done       (done),
    .done_code  (done_code),
    .cycle_count(cycle_count),
    .bus_timeout(bus_timeout)
  );

  always #5 clk = ~clk;

  // RAM model: ram_ready in the ram_delay-th cycle of ram_valid; delay 0 never answers.
  always @(negedge clk) begin
    if (ram_valid) ram_cnt = ram_cnt + 1;
    else           ram_cnt = 0;
    ram_ready = (ram_delay != 0) && ram_valid && (ram_cnt == ram_delay);
  end

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          delay;
    logic [31:0] rram;
    logic [31:0] exp_rdata;
    int          exp_lat;
    int          exp_rv;
    logic        exp_done;
    logic [31:0] exp_code;
    logic        exp_to;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end else begin
      $display("ok   %s: %h", nm, act);
    end
  endtask

  // One bus transaction; returns rdata, cycles to mem_ready, ram_valid cycles and latched RAM request.
  task automatic do_req(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                        output logic [31:0] rd, output int lat, output int rv,
                        output logic [31:0] ra, output logic [31:0] rwd, output logic [3:0] rws);
    logic got;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wstrb = wstrb;
    got = 1'b0; lat = 0; rv = 0; rd = 32'h0; ra = 32'h0; rwd = 32'h0; rws = 4'h0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ram_valid) begin
        rv++;
        ra = ram_addr; rwd = ram_wdata; rws = ram_wstrb;
      end
      if (mem_ready) begin
        got = 1'b1;
        rd  = mem_rdata;
      end
    end
    mem_valid = 1'b0;
    mem_wstrb = 4'h0;
    chk($sformatf("ready_seen@%h", addr), 64'(got), 64'd1);
    @(posedge clk); #1;
    chk($sformatf("ready_one_cycle@%h", addr), 64'(mem_ready), 64'd0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("rst_mem_ready",   64'(mem_ready),   64'd0);
    chk("rst_mem_rdata",   64'(mem_rdata),   64'd0);
    chk("rst_ram_valid",   64'(ram_valid),   64'd0);
    chk("rst_ram_addr",    64'(ram_addr),    64'd0);
    chk("rst_done",        64'(done),        64'd0);
    chk("rst_done_code",   64'(done_code),   64'd0);
    chk("rst_cycle_count", cycle_count,      64'd0);
    chk("rst_bus_timeout", 64'(bus_timeout), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] rd, ra, rwd;
    logic [3:0]  rws;
    int          lat, rv, rdy_cnt, rv_cnt;
    logic [63:0] c0;

    //        addr          wdata         strb   dly rram          exp_rdata     lat rv done code          to
    vecs[0]  = '{32'h200, 32'h0,        4'h0, 3, 32'h1234_5678, 32'h1234_5678, 4, 3, 1'b0, 32'h0, 1'b0};
    vecs[1]  = '{32'h010, 32'h1,        4'hF, 0, 32'h0,         32'h0,         1, 0, 1'b1, 32'h1, 1'b0};
    vecs[2]  = '{32'h010, 32'h5,        4'hF, 0, 32'h0,         32'h0,         1, 0, 1'b1, 32'h1, 1'b0};
    vecs[3]  = '{32'h010, 32'h0,        4'h0, 0, 32'h0,         32'h1,         1, 0, 1'b1, 32'h1, 1'b0};
    vecs[4]  = '{32'h01C, 32'h0,        4'h0, 0, 32'h0,         32'h1,         1, 0, 1'b1, 32'h1, 1'b0};
    vecs[5]  = '{32'h300, 32'h0,        4'h0, 0, 32'h5555_5555, 32'hDEAD_BEEF, 9, 8, 1'b1, 32'h1, 1'b1};
    vecs[6]  = '{32'h01C, 32'h0,        4'h0, 0, 32'h0,         32'h3,         1, 0, 1'b1, 32'h1, 1'b1};
    vecs[7]  = '{32'h018, 32'hFFFF,     4'hF, 0, 32'h0,         32'h0,         1, 0, 1'b1, 32'h1, 1'b1};
    vecs[8]  = '{32'h01F, 32'h0,        4'h0, 0, 32'h0,         32'h3,         1, 0, 1'b1, 32'h1, 1'b1};
    vecs[9]  = '{32'h020, 32'h0,        4'h0, 1, 32'hCAFE_F00D, 32'hCAFE_F00D, 2, 1, 1'b1, 32'h1, 1'b1};
    vecs[10] = '{32'h400, 32'h1122_3344, 4'h3, 2, 32'h9999_9999, 32'h0,        3, 2, 1'b1, 32'h1, 1'b1};
    vecs[11] = '{32'h00C, 32'h0,        4'h0, 1, 32'h0BAD_F00D, 32'h0BAD_F00D, 2, 1, 1'b1, 32'h1, 1'b1};

    apply_reset();

    // Counter read after 10 idle cycles: accept edge sees the value 10.
    repeat (10) @(posedge clk);
    do_req(32'h14, 32'h0, 4'h0, rd, lat, rv, ra, rwd, rws);
    chk("cyc_lo_first", 64'(rd), 64'd10);
    chk("cyc_lo_lat", 64'(lat), 64'd1);
    chk("cyc_lo_done", 64'(done), 64'd0);

    for (int v = 0; v < 12; v++) begin
      ram_delay = vecs[v].delay;
      ram_rdata = vecs[v].rram;
      do_req(vecs[v].addr, vecs[v].wdata, vecs[v].wstrb, rd, lat, rv, ra, rwd, rws);
      chk($sformatf("v%0d_rdata", v),   64'(rd),          64'(vecs[v].exp_rdata));
      chk($sformatf("v%0d_lat", v),     64'(lat),         64'(vecs[v].exp_lat));
      chk($sformatf("v%0d_ramvld", v),  64'(rv),          64'(vecs[v].exp_rv));
      chk($sformatf("v%0d_done", v),    64'(done),        64'(vecs[v].exp_done));
      chk($sformatf("v%0d_code", v),    64'(done_code),   64'(vecs[v].exp_code));
      chk($sformatf("v%0d_timeout", v), 64'(bus_timeout), 64'(vecs[v].exp_to));
      if (vecs[v].exp_rv > 0) begin
        chk($sformatf("v%0d_ram_addr", v),  64'(ra),  64'(vecs[v].addr));
        chk($sformatf("v%0d_ram_wdata", v), 64'(rwd), 64'(vecs[v].wdata));
        chk($sformatf("v%0d_ram_wstrb", v), 64'(rws), 64'(vecs[v].wstrb));
      end
    end
    ram_delay = 0;

    // Counter stays frozen once done is set.
    c0 = cycle_count;
    repeat (20) @(posedge clk);
    #1;
    chk("freeze_count", cycle_count, c0);
    do_req(32'h14, 32'h0, 4'h0, rd, lat, rv, ra, rwd, rws);
    chk("freeze_lo_read", 64'(rd), 64'(c0[31:0]));

    // Fresh reset: byte-merged first DONE write; HI snapshot starts at zero.
    apply_reset();
    do_req(32'h18, 32'h0, 4'h0, rd, lat, rv, ra, rwd, rws);
    chk("rst_hi_snapshot", 64'(rd), 64'd0);
    do_req(32'h10, 32'hFFFF_FFA5, 4'h1, rd, lat, rv, ra, rwd, rws);
    chk("merge_code", 64'(done_code), 64'h0000_00A5);
    chk("merge_done", 64'(done), 64'd1);
    chk("merge_rdata", 64'(rd), 64'd0);

    // Low-word carry: HI must return the snapshot taken by the LO read, not the live value.
    apply_reset();
    @(negedge clk);
    force dut.cycle_q = 64'h0000_0000_FFFF_FFF0;
    @(negedge clk);
    release dut.cycle_q;
    do_req(32'h14, 32'h0, 4'h0, rd, lat, rv, ra, rwd, rws);
    chk("carry_lo_near_wrap", 64'(rd >= 32'hFFFF_FFF0 && rd < 32'hFFFF_FFFC), 64'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("carry_live_hi", 64'(cycle_count[63:32]), 64'd1);
    do_req(32'h18, 32'h0, 4'h0, rd, lat, rv, ra, rwd, rws);
    chk("carry_hi_snapshot_old", 64'(rd), 64'd0);
    do_req(32'h14, 32'h0, 4'h0, rd, lat, rv, ra, rwd, rws);
    chk("carry_lo_after", 64'(rd < 32'h0000_0040), 64'd1);
    do_req(32'h18, 32'h0, 4'h0, rd, lat, rv, ra, rwd, rws);
    chk("carry_hi_snapshot_new", 64'(rd), 64'd1);

    // Reset while waiting on RAM drops the request with no response afterwards.
    ram_delay = 0;
    @(negedge clk);
    mem_valid = 1'b1;
    mem_addr  = 32'h500;
    mem_wstrb = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_ram_active", 64'(ram_valid), 64'd1);
    #2;
    rst_n     = 1'b0;
    mem_valid = 1'b0;
    #1;
    chk("midrst_ram_valid", 64'(ram_valid), 64'd0);
    chk("midrst_mem_ready", 64'(mem_ready), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rdy_cnt = 0;
    rv_cnt  = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (mem_ready) rdy_cnt++;
      if (ram_valid) rv_cnt++;
    end
    chk("midrst_no_resp", 64'(rdy_cnt), 64'd0);
    chk("midrst_no_ram", 64'(rv_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_sysctl.md
Name: mmio_sysctl

Overview:
- Sits between the CPU core's native memory port (mem_valid/mem_ready handshake) and the RAM model.
- Decodes a small system-control window (DONE/exit-code flag, 64-bit cycle counter, status) and forwards all other accesses to RAM.
- Provides a RAM access timeout so a hung memory returns an error pattern instead of stalling the core.
- The bench and later SoC-level logic use done/done_code instead of snooping raw bus writes.

Parameters:
- MMIO_BASE, 32'h0000_0010, byte address of DONE register; window is MMIO_BASE..MMIO_BASE+0xF.
- RAM_TIMEOUT, 1024, RAM_WAIT cycles before the access is aborted (>=2).
- ERR_DATA, 32'hDEAD_BEEF, read data returned on a timed-out RAM access.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- mem_valid  in  1  CPU request; held until mem_ready
- mem_instr  in  1  instruction fetch qualifier (passed to RAM, otherwise ignored)
- mem_addr  in  32  byte address
- mem_wdata  in  32  write data
- mem_wstrb  in  4  byte strobes; 0 = read
- mem_ready  out  1  one-cycle response pulse
- mem_rdata  out  32  read data, valid with mem_ready
- ram_valid  out  1  RAM request
- ram_instr  out  1  latched mem_instr
- ram_addr  out  32  latched address
- ram_wdata  out  32  latched write data
- ram_wstrb  out  4  latched strobes
- ram_ready  in  1  RAM completion
- ram_rdata  in  32  RAM read data
- done  out  1  sticky program-finished flag
- done_code  out  32  exit code written to DONE
- cycle_count  out  64  free-running cycle counter
- bus_timeout  out  1  sticky RAM timeout flag

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0, including mem_ready, mem_rdata, ram_*, done, done_code, cycle_count, bus_timeout and the CYCLE_HI snapshot. An in-flight RAM request is dropped immediately (ram_valid low); no response is issued.
- Register map (word offsets from MMIO_BASE):
  - +0x0 DONE: RW. A write with any nonzero strobe sets done and loads done_code, byte-merged per mem_wstrb over 0. Only the first write takes effect; later writes are acked and ignored. A read returns done_code.
  - +0x4 CYCLE_LO: RO. Returns cycle_count[31:0] and snapshots cycle_count[63:32] into CYCLE_HI on the same edge.
  - +0x8 CYCLE_HI: RO. Returns the snapshot.
  - +0xC STATUS: RO. {30'b0, bus_timeout, done}.
  - Writes to RO registers are acked with no effect. mem_rdata = 0 on every write response.
- Address decode: mem_addr[31:4] == MMIO_BASE[31:4]; mem_addr[1:0] ignored.
- FSM states: IDLE, MMIO_RESP, RAM_WAIT, RAM_RESP.
  - IDLE + mem_valid + MMIO hit -> MMIO_RESP. The register action is performed on this edge.
  - IDLE + mem_valid + miss -> RAM_WAIT. mem_instr/addr/wdata/wstrb are latched onto ram_*; ram_valid = 1 from the next cycle.
  - MMIO_RESP: mem_ready = 1 for exactly one cycle, then -> IDLE. Latency is mem_valid sampled -> mem_ready one cycle later.
  - RAM_WAIT + ram_ready -> RAM_RESP. ram_rdata is captured; ram_valid drops on the same edge.
  - RAM_WAIT + timeout counter == RAM_TIMEOUT-1 without ram_ready -> RAM_RESP with rdata = ERR_DATA, bus_timeout set. If ram_ready and timeout coincide, ram_ready wins with no timeout.
  - RAM_RESP: mem_ready = 1 for one cycle, then -> IDLE.
  - In MMIO_RESP and RAM_RESP, mem_valid is not sampled. A new request is accepted in IDLE on the following cycle at the earliest.
  - The timeout counter clears on entry to RAM_WAIT.
- Cycle counter:
  - Increments by 1 every cycle after reset release.
  - Wraps modulo 2^64.
  - Freezes from the cycle after done is set.
  - A CYCLE_LO read returns the pre-increment value sampled on the accept edge.
- mem_rdata holds its last value outside mem_ready pulses; it is only meaningful during the pulse.

Test Plan:
- Reset release, idle 10 cycles, read CYCLE_LO at 0x14 -> mem_ready 1 cycle after valid; rdata equals counter at accept edge (~10); done = 0.
- Write 0x0000_0001 to 0x10 with wstrb 4'b1111 -> mem_ready after 1 cycle; done = 1, done_code = 1. Counter freezes (stays constant over next 20 cycles). Second write 0x5 -> acked, done_code still 1.
- Write 0xA5 to 0x10 with wstrb 4'b0001 -> done_code = 0x0000_00A5.
- Read 0x200 with RAM returning ram_ready after 3 cycles and rdata 0x1234_5678 -> ram_addr = 0x200 and ram_valid high 3 cycles. mem_ready one cycle after ram_ready with rdata 0x1234_5678; bus_timeout = 0.
- RAM never responds (RAM_TIMEOUT = 8) -> ram_valid high exactly 8 cycles; mem_ready with 0xDEAD_BEEF; STATUS read = 0x2.
- Preload counter near 2^32-1 (force), read 0x14 then 0x18 across a low-word carry -> HI snapshot consistent with LO. rst_n low mid-RAM_WAIT -> ram_valid and mem_ready low immediately, no response after release.
